// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style multiply/divide unit with HI/LO result registers.
// MULT/MULTU/DIV/DIVU take WIDTH iteration cycles plus one fix-up cycle.
// MTHI/MTLO write HI/LO directly in one cycle while the unit is idle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [5:0]       i_control,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div0
);

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             r_state;
  state_t             w_next;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_div0;
  logic               r_isDiv;
  logic               r_negQ;
  logic               r_negR;
  logic               r_zeroDiv;

  logic               w_isMul;
  logic               w_isDiv;
  logic               w_ldMul;
  logic               w_ldDiv;
  logic               w_mthi;
  logic               w_mtlo;
  logic               w_step;
  logic               w_lastStep;
  logic               w_fix;
  logic               w_signed;
  logic               w_s1;
  logic               w_s2;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH:0]     w_mulSum;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_remd;

  // Operand decode: signed ops (funct bit 0 clear) use exact magnitudes; -MIN wraps to 2**(WIDTH-1).
  assign w_isMul  = (i_control == FN_MULT) || (i_control == FN_MULTU);
  assign w_isDiv  = (i_control == FN_DIV)  || (i_control == FN_DIVU);
  assign w_signed = ~i_control[0];
  assign w_s1     = w_signed & i_op1[WIDTH-1];
  assign w_s2     = w_signed & i_op2[WIDTH-1];
  assign w_mag1   = w_s1 ? -i_op1 : i_op1;
  assign w_mag2   = w_s2 ? -i_op2 : i_op2;

  // Shift-add step: add multiplicand into the upper half when the current multiplier bit is set.
  assign w_mulSum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);

  // Restoring divide step: the partial remainder never exceeds twice the divisor, so bit WIDTH is a valid sign.
  assign w_trial  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_trial - {1'b0, r_a};
  assign w_ge     = ~w_diff[WIDTH];

  // Final sign correction; divide-by-zero and MIN/-1 fall out of the magnitude datapath naturally.
  assign w_prod   = r_negQ ? -r_acc : r_acc;
  assign w_quot   = r_negQ ? -r_quo : r_quo;
  assign w_remd   = r_negR ? -r_rem : r_rem;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic: WIDTH iteration cycles, then one fix-up cycle back to idle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ldMul)      w_next = S_MUL;
        else if (w_ldDiv) w_next = S_DIV;
      end
      S_MUL:   if (w_lastStep) w_next = S_FIX;
      S_DIV:   if (w_lastStep) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control decode per state: start requests only count while idle, which also filters MTHI/MTLO.
  always_comb begin
    w_ldMul    = 1'b0;
    w_ldDiv    = 1'b0;
    w_mthi     = 1'b0;
    w_mtlo     = 1'b0;
    w_step     = 1'b0;
    w_fix      = 1'b0;
    w_lastStep = (r_cnt == CNT_W'(WIDTH - 1));
    case (r_state)
      S_IDLE: begin
        w_ldMul = i_start & w_isMul;
        w_ldDiv = i_start & w_isDiv;
        w_mthi  = i_start & (i_control == FN_MTHI);
        w_mtlo  = i_start & (i_control == FN_MTLO);
      end
      S_MUL:   w_step = 1'b1;
      S_DIV:   w_step = 1'b1;
      S_FIX:   w_fix  = 1'b1;
      default: w_step = 1'b0;
    endcase
  end

  // Operand latch and iteration datapath; operands are captured once at the start edge only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a       <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_isDiv   <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_zeroDiv <= 1'b0;
    end else if (w_ldMul) begin
      r_a       <= w_mag1;
      r_acc     <= {{WIDTH{1'b0}}, w_mag2};
      r_cnt     <= '0;
      r_isDiv   <= 1'b0;
      r_negQ    <= w_s1 ^ w_s2;
      r_negR    <= 1'b0;
      r_zeroDiv <= 1'b0;
    end else if (w_ldDiv) begin
      r_a       <= w_mag2;
      r_rem     <= '0;
      r_quo     <= w_mag1;
      r_cnt     <= '0;
      r_isDiv   <= 1'b1;
      r_negQ    <= w_s1 ^ w_s2;
      r_negR    <= w_s1;
      r_zeroDiv <= (i_op2 == '0);
    end else if (w_step) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_state == S_MUL) begin
        r_acc <= {w_mulSum, r_acc[WIDTH-1:1]};
      end else begin
        r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_ge};
      end
    end else if (w_fix) begin
      r_cnt <= '0;
    end
  end

  // HI/LO update: results only at the fix-up edge, direct moves only while idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fix) begin
      if (r_isDiv) begin
        r_hi <= w_remd;
        r_lo <= w_quot;
      end else begin
        r_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_lo <= w_prod[WIDTH-1:0];
      end
    end else if (w_mthi) begin
      r_hi <= i_op1;
    end else if (w_mtlo) begin
      r_lo <= i_op1;
    end
  end

  // Handshake flags: busy spans start edge to fix edge, done/div0 pulse for the cycle after fix.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_div0 <= 1'b0;
    end else begin
      if (w_ldMul || w_ldDiv) r_busy <= 1'b1;
      else if (w_fix)         r_busy <= 1'b0;
      r_done <= w_fix;
      r_div0 <= w_fix & r_isDiv & r_zeroDiv;
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_div0 = r_div0;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed plus randomized checks of muldiv_unit against a 64-bit arithmetic reference.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MTLO  = 6'b010011;

  logic         clk = 1'b0;
  logic         rstN;
  logic         start;
  logic [5:0]   ctrl;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div0;

  int total = 0;
  int bad   = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .i_clk     (clk),
    .i_rst_n   (rstN),
    .i_start   (start),
    .i_control (ctrl),
    .i_op1     (op1),
    .i_op2     (op2),
    .o_hi      (hi),
    .o_lo      (lo),
    .o_busy    (busy),
    .o_done    (done),
    .o_div0    (div0)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference results straight from signed/unsigned 64-bit arithmetic and the documented special cases.
  function automatic void refModel(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] eHi, output logic [W-1:0] eLo, output logic eD0);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    eD0 = 1'b0;
    eHi = '0;
    eLo = '0;
    p   = '0;
    case (fn)
      MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        eHi = p[63:32];
        eLo = p[31:0];
      end
      MULT: begin
        p = 64'(sa * sb);
        eHi = p[63:32];
        eLo = p[31:0];
      end
      DIVU: begin
        if (b == 0) begin
          eLo = '1; eHi = a; eD0 = 1'b1;
        end else begin
          eLo = a / b; eHi = a % b;
        end
      end
      DIV: begin
        if (b == 0) begin
          eLo = a[W-1] ? 32'd1 : '1; eHi = a; eD0 = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          eLo = 32'h8000_0000; eHi = '0;
        end else begin
          eLo = 32'(sa / sb); eHi = 32'(sa % sb);
        end
      end
      default: begin
        eHi = '0; eLo = '0;
      end
    endcase
  endfunction

  // Issue one mul/div, scramble operands afterwards, optionally poke MTLO while busy, then check everything.
  task automatic applyStimulus(input string tag, input logic [5:0] fn, input logic [W-1:0] a,
                               input logic [W-1:0] b, input bit midMt);
    logic [W-1:0] expHi;
    logic [W-1:0] expLo;
    logic [W-1:0] preHi;
    logic [W-1:0] preLo;
    logic         expD0;
    int           n;
    int           busyCnt;
    int           guard;
    bit           held;
    bit           gotDone;
    refModel(fn, a, b, expHi, expLo, expD0);
    guard = 0;
    while (busy && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    preHi = hi;
    preLo = lo;
    start = 1'b1; ctrl = fn; op1 = a; op2 = b;
    @(posedge clk); #1;
    start = 1'b0; op1 = $urandom; op2 = $urandom; ctrl = 6'($urandom);
    checkOutput({tag, "_startEdge"}, {busy, done, div0}, 3'b100);
    busyCnt = 1; n = 0; held = 1'b1; gotDone = 1'b0;
    while (!gotDone && n < 100) begin
      if (midMt && n == 5) begin
        start = 1'b1; ctrl = MTLO; op1 = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1; n++;
      if (busy) busyCnt++;
      if (done) gotDone = 1'b1;
      else if (hi !== preHi || lo !== preLo) held = 1'b0;
    end
    start = 1'b0;
    checkOutput({tag, "_latency"}, n, W + 1);
    checkOutput({tag, "_busyCycles"}, busyCnt, W + 1);
    checkOutput({tag, "_hiloHeld"}, held, 1'b1);
    checkOutput({tag, "_hi"}, hi, expHi);
    checkOutput({tag, "_lo"}, lo, expLo);
    checkOutput({tag, "_doneDiv0"}, {done, div0}, {1'b1, expD0});
  endtask

  // Directed sequence followed by randomized operations and a mid-operation reset.
  initial begin
    logic [5:0]   fnTab [4];
    logic [5:0]   fn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           spurious;
    fnTab[0] = MULT; fnTab[1] = MULTU; fnTab[2] = DIV; fnTab[3] = DIVU;
    rstN = 1'b0; start = 1'b0; ctrl = '0; op1 = '0; op2 = '0;
    #1;
    checkOutput("reset_outputs", {hi, lo, busy, done, div0}, '0);
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_reset_idle", {hi, lo, busy, done, div0}, '0);

    applyStimulus("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("mult_neg3x7", MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    applyStimulus("mult_minxmin", MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    applyStimulus("div_m7by2", DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    applyStimulus("divu_100by7", DIVU, 32'd100, 32'd7, 1'b0);
    applyStimulus("div_overflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus("divu_5by0", DIVU, 32'd5, 32'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("div0_pulse_fall", {done, div0}, 2'b00);
    applyStimulus("div_neg5by0", DIV, 32'hFFFF_FFFB, 32'd0, 1'b0);
    applyStimulus("div_pos9by0", DIV, 32'd9, 32'd0, 1'b0);

    start = 1'b1; ctrl = MTHI; op1 = 32'h0000_1234; op2 = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("mthi_value", hi, 32'h0000_1234);
    checkOutput("mthi_no_handshake", {busy, done, div0}, 3'b000);
    @(posedge clk); #1;
    checkOutput("mthi_hold", {hi, busy, done}, {32'h0000_1234, 2'b00});

    start = 1'b1; ctrl = MTLO; op1 = 32'hCAFE_0001;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("mtlo_value", {lo, hi, done}, {32'hCAFE_0001, 32'h0000_1234, 1'b0});

    applyStimulus("mult_mtlo_busy", MULT, 32'hFFFF_FF00, 32'd1000, 1'b1);
    applyStimulus("divu_mtlo_busy", DIVU, 32'hDEAD_BEEF, 32'd12345, 1'b1);

    for (int i = 0; i < 24; i++) begin
      fn = fnTab[$urandom_range(0, 3)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      applyStimulus($sformatf("rand%0d", i), fn, a, b, 1'b0);
    end

    start = 1'b1; ctrl = DIV; op1 = 32'h7654_3210; op2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("reset_mid_div", {hi, lo, busy, done, div0}, '0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    spurious = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy || div0) spurious = 1'b1;
    end
    checkOutput("no_done_after_reset", spurious, 1'b0);
    applyStimulus("multu_3x5", MULTU, 32'd3, 32'd5, 1'b0);
    @(posedge clk); #1;
    checkOutput("final_done_fall", {busy, done, div0}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
